pkg_wr_ctrl: RTL and testbench

Per-channel packet write controller directly upstream of the packet read controller. It accepts byte-wide packets with sop/eop framing and writes them into the high-priority RAM (descending addresses) or the low-priority RAM (ascending addresses), selected by the packet's qos. It publishes committed write pointers only at packet boundaries, so the reader never sees a partial packet. Packets that cannot be stored completely are dropped and rolled back.

---
 rtl/pkg_wr_ctrl_if.sv | 41 ++++
 rtl/pkg_wr_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_pkg_wr_ctrl.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pkg_wr_ctrl_if.sv
// pkg_wr_ctrl_if: packet ingress, RAM write ports and status of one packet write controller.
//   master : packet source / reader side (drives in_*, *_raddr; observes write ports + status)
//   slave  : the write controller (consumes in_*, *_raddr; drives write ports + status)
//   in_valid/in_sop/in_eop/in_qos/in_data : byte beats with sop/eop framing, no backpressure
//   hram_raddr/lram_raddr                 : reader's current read addresses
//   hram_w*/lram_w*                       : registered RAM write strobe/address/word
//   high_real_waddr/low_real_waddr        : committed write pointers seen by the reader
//   drop_pulse/drop_cnt                   : drop event strobe and saturating count
interface pkg_wr_ctrl_if #(
   parameter int unsigned ADDR_WIDTH = 11
);
   logic                  in_valid;
   logic                  in_sop;
   logic                  in_eop;
   logic                  in_qos;
   logic [7:0]            in_data;
   logic [ADDR_WIDTH-1:0] hram_raddr;
   logic [ADDR_WIDTH-1:0] lram_raddr;
   logic                  hram_wen;
   logic [ADDR_WIDTH-1:0] hram_waddr;
   logic [10:0]           hram_wdata;
   logic                  lram_wen;
   logic [ADDR_WIDTH-1:0] lram_waddr;
   logic [10:0]           lram_wdata;
   logic [ADDR_WIDTH-1:0] high_real_waddr;
   logic [ADDR_WIDTH-1:0] low_real_waddr;
   logic                  drop_pulse;
   logic [15:0]           drop_cnt;

   modport master (
      output in_valid, in_sop, in_eop, in_qos, in_data, hram_raddr, lram_raddr,
      input  hram_wen, hram_waddr, hram_wdata, lram_wen, lram_waddr, lram_wdata,
      input  high_real_waddr, low_real_waddr, drop_pulse, drop_cnt
   );

   modport slave (
      input  in_valid, in_sop, in_eop, in_qos, in_data, hram_raddr, lram_raddr,
      output hram_wen, hram_waddr, hram_wdata, lram_wen, lram_waddr, lram_wdata,
      output high_real_waddr, low_real_waddr, drop_pulse, drop_cnt
   );
endinterface

// File: rtl/pkg_wr_ctrl.sv
// pkg_wr_ctrl: per-channel packet write controller. Stores sop/eop framed byte packets into the
// high RAM (descending addresses, qos=1) or low RAM (ascending, qos=0) and publishes the write
// pointers only at packet boundaries. Packets that cannot be stored whole are rolled back.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : pkg_wr_ctrl_if.slave (packet input, reader addresses, RAM writes, status)
module pkg_wr_ctrl #(
   parameter int unsigned RAM_DEPTH  = 1144,
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned MAX_LEN    = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   pkg_wr_ctrl_if.slave bus
);

   localparam logic [ADDR_WIDTH-1:0] TopAddr = ADDR_WIDTH'(RAM_DEPTH - 1);
   localparam int unsigned           CntW    = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {StIdle, StWrite, StDiscard} state_e;

   // High side walks down, low side walks up, both wrapping mod RAM_DEPTH.
   function automatic logic [ADDR_WIDTH-1:0] step_ptr(input logic hi,
                                                      input logic [ADDR_WIDTH-1:0] p);
      if (hi) return (p == '0) ? TopAddr : p - 1'b1;
      else    return (p == TopAddr) ? '0 : p + 1'b1;
   endfunction

   // free = (RAM_DEPTH-1) - ((head - tail) mod RAM_DEPTH)
   function automatic logic [ADDR_WIDTH:0] free_slots(input logic [ADDR_WIDTH-1:0] head,
                                                      input logic [ADDR_WIDTH-1:0] tail);
      logic [ADDR_WIDTH:0] used;
      if (head >= tail) used = {1'b0, head} - {1'b0, tail};
      else              used = {1'b0, head} + (ADDR_WIDTH+1)'(RAM_DEPTH) - {1'b0, tail};
      return (ADDR_WIDTH+1)'(RAM_DEPTH - 1) - used;
   endfunction

   state_e                r_state, w_state;
   logic                  r_qos, w_qos;
   logic [CntW-1:0]       r_cnt, w_cnt;
   logic [ADDR_WIDTH-1:0] r_wp_h, w_wp_h, r_wp_l, w_wp_l;   // working pointers
   logic [ADDR_WIDTH-1:0] r_cp_h, w_cp_h, r_cp_l, w_cp_l;   // committed at eop
   logic [ADDR_WIDTH-1:0] r_cpd_h, r_cpd_l, r_real_h, r_real_l;
   logic                  r_hwen, w_hwen, r_lwen, w_lwen;
   logic [ADDR_WIDTH-1:0] r_hwaddr, w_hwaddr, r_lwaddr, w_lwaddr;
   logic [10:0]           r_hwdata, w_hwdata, r_lwdata, w_lwdata;
   logic                  r_drop_pulse;
   logic [15:0]           r_drop_cnt, w_drop_cnt;
   logic [1:0]            w_drops;
   logic [16:0]           w_drop_sum;
   logic [ADDR_WIDTH:0]   w_free_h, w_free_l, w_free_sel;

   // Free space is judged against the pointer committed at eop, which leads the published copy,
   // so a back-to-back sop never counts the previous packet's slots as free.
   assign w_free_h   = free_slots(bus.hram_raddr, r_cp_h);
   assign w_free_l   = free_slots(r_cp_l, bus.lram_raddr);
   assign w_free_sel = bus.in_qos ? w_free_h : w_free_l;

   always_comb begin
      w_state  = r_state;
      w_qos    = r_qos;
      w_cnt    = r_cnt;
      w_wp_h   = r_wp_h;
      w_wp_l   = r_wp_l;
      w_cp_h   = r_cp_h;
      w_cp_l   = r_cp_l;
      w_hwen   = 1'b0;
      w_hwaddr = r_hwaddr;
      w_hwdata = r_hwdata;
      w_lwen   = 1'b0;
      w_lwaddr = r_lwaddr;
      w_lwdata = r_lwdata;
      w_drops  = 2'd0;
      if (bus.in_valid) begin
         if (bus.in_sop) begin
            // A sop inside an open packet aborts it; the sop itself is then judged afresh.
            if (r_state == StWrite) begin
               w_drops = w_drops + 2'd1;
               if (r_qos) w_wp_h = r_cp_h;
               else       w_wp_l = r_cp_l;
            end
            if (w_free_sel >= (ADDR_WIDTH+1)'(MAX_LEN)) begin
               w_qos = bus.in_qos;
               w_cnt = CntW'(1);
               if (bus.in_qos) begin
                  w_hwen   = 1'b1;
                  w_hwaddr = r_cp_h;
                  w_hwdata = {2'b01, bus.in_eop, bus.in_data};
                  w_wp_h   = step_ptr(1'b1, r_cp_h);
                  if (bus.in_eop) w_cp_h = step_ptr(1'b1, r_cp_h);
               end else begin
                  w_lwen   = 1'b1;
                  w_lwaddr = r_cp_l;
                  w_lwdata = {2'b01, bus.in_eop, bus.in_data};
                  w_wp_l   = step_ptr(1'b0, r_cp_l);
                  if (bus.in_eop) w_cp_l = step_ptr(1'b0, r_cp_l);
               end
               w_state = bus.in_eop ? StIdle : StWrite;
            end else begin
               w_drops = w_drops + 2'd1;
               w_state = bus.in_eop ? StIdle : StDiscard;
            end
         end else begin
            case (r_state)
               StIdle: w_drops = 2'd1;  // stray beat outside any packet
               StWrite: begin
                  if (r_cnt == CntW'(MAX_LEN)) begin
                     w_drops = 2'd1;
                     if (r_qos) w_wp_h = r_cp_h;
                     else       w_wp_l = r_cp_l;
                     w_state = bus.in_eop ? StIdle : StDiscard;
                  end else begin
                     w_cnt = r_cnt + 1'b1;
                     if (r_qos) begin
                        w_hwen   = 1'b1;
                        w_hwaddr = r_wp_h;
                        w_hwdata = {2'b00, bus.in_eop, bus.in_data};
                        w_wp_h   = step_ptr(1'b1, r_wp_h);
                        if (bus.in_eop) w_cp_h = step_ptr(1'b1, r_wp_h);
                     end else begin
                        w_lwen   = 1'b1;
                        w_lwaddr = r_wp_l;
                        w_lwdata = {2'b00, bus.in_eop, bus.in_data};
                        w_wp_l   = step_ptr(1'b0, r_wp_l);
                        if (bus.in_eop) w_cp_l = step_ptr(1'b0, r_wp_l);
                     end
                     if (bus.in_eop) w_state = StIdle;
                  end
               end
               StDiscard: if (bus.in_eop) w_state = StIdle;
               default:   w_state = StIdle;
            endcase
         end
      end
      w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drops);
      w_drop_cnt = w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StIdle;
         r_qos        <= 1'b0;
         r_cnt        <= '0;
         r_wp_h       <= TopAddr;
         r_cp_h       <= TopAddr;
         r_cpd_h      <= TopAddr;
         r_real_h     <= TopAddr;
         r_wp_l       <= '0;
         r_cp_l       <= '0;
         r_cpd_l      <= '0;
         r_real_l     <= '0;
         r_hwen       <= 1'b0;
         r_hwaddr     <= '0;
         r_hwdata     <= '0;
         r_lwen       <= 1'b0;
         r_lwaddr     <= '0;
         r_lwdata     <= '0;
         r_drop_pulse <= 1'b0;
         r_drop_cnt   <= '0;
      end else begin
         r_state      <= w_state;
         r_qos        <= w_qos;
         r_cnt        <= w_cnt;
         r_wp_h       <= w_wp_h;
         r_cp_h       <= w_cp_h;
         r_wp_l       <= w_wp_l;
         r_cp_l       <= w_cp_l;
         // Publish two edges after eop: one cycle after the eop word hits the RAM.
         r_cpd_h      <= r_cp_h;
         r_real_h     <= r_cpd_h;
         r_cpd_l      <= r_cp_l;
         r_real_l     <= r_cpd_l;
         r_hwen       <= w_hwen;
         r_hwaddr     <= w_hwaddr;
         r_hwdata     <= w_hwdata;
         r_lwen       <= w_lwen;
         r_lwaddr     <= w_lwaddr;
         r_lwdata     <= w_lwdata;
         r_drop_pulse <= (w_drops != 2'd0);
         r_drop_cnt   <= w_drop_cnt;
      end
   end

   assign bus.hram_wen        = r_hwen;
   assign bus.hram_waddr      = r_hwaddr;
   assign bus.hram_wdata      = r_hwdata;
   assign bus.lram_wen        = r_lwen;
   assign bus.lram_waddr      = r_lwaddr;
   assign bus.lram_wdata      = r_lwdata;
   assign bus.high_real_waddr = r_real_h;
   assign bus.low_real_waddr  = r_real_l;
   assign bus.drop_pulse      = r_drop_pulse;
   assign bus.drop_cnt        = r_drop_cnt;

endmodule

// File: tb/tb_pkg_wr_ctrl.sv
// tb_pkg_wr_ctrl: directed scenarios with literal expectations plus randomized traffic, all
// checked every cycle against a packet-level reference model of pkg_wr_ctrl.
module tb_pkg_wr_ctrl;
   localparam int D   = 1144;
   localparam int MAX = 64;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pkg_wr_ctrl_if #(.ADDR_WIDTH(11)) bus ();

   pkg_wr_ctrl #(.RAM_DEPTH(D), .ADDR_WIDTH(11), .MAX_LEN(MAX)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model, index 1 = high RAM, 0 = low RAM.
   int m_cp[2];       // committed (next free) address, updated at the eop
   int m_d1[2];       // committed address one edge ago
   int m_pub[2];      // what the reader must see (committed two edges ago)
   bit m_open;        // a packet is being stored
   bit m_skip;        // discarding the rest of a dropped packet
   int m_q;           // RAM of the open packet
   int m_len;         // words stored so far in the open packet
   int m_dcnt;
   bit e_pulse;
   bit e_wen[2];
   int e_waddr[2];
   int e_wdata[2];

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic m_reset();
      m_cp[1] = D - 1; m_cp[0] = 0;
      m_d1 = m_cp; m_pub = m_cp;
      m_open = 0; m_skip = 0; m_q = 0; m_len = 0; m_dcnt = 0; e_pulse = 0;
      e_wen[0] = 0; e_wen[1] = 0;
   endtask

   // k-th word of a packet starting at the committed address
   function automatic int beat_addr(int q, int k);
      return q ? (m_cp[1] + D - k) % D : (m_cp[0] + k) % D;
   endfunction

   function automatic int free_of(int q);
      int used;
      used = q ? (int'(bus.hram_raddr) - m_cp[1] + D) % D : (m_cp[0] - int'(bus.lram_raddr) + D) % D;
      return D - 1 - used;
   endfunction

   task automatic store(input bit s, input bit e, input int d);
      e_wen[m_q]   = 1;
      e_waddr[m_q] = beat_addr(m_q, m_len);
      e_wdata[m_q] = s * 512 + e * 256 + d;
      m_len++;
   endtask

   task automatic model_step();
      int drops, q, d;
      bit v, s, e;
      v = bus.in_valid; s = bus.in_sop; e = bus.in_eop; q = int'(bus.in_qos);
      d = int'(bus.in_data);
      drops = 0;
      m_pub = m_d1;
      m_d1 = m_cp;
      e_wen[0] = 0; e_wen[1] = 0;
      if (v) begin
         if (s) begin
            if (m_open) drops++;
            m_open = 0; m_skip = 0;
            if (free_of(q) >= MAX) begin
               m_q = q; m_len = 0;
               store(1, e, d);
               if (e) m_cp[m_q] = beat_addr(m_q, m_len);
               else   m_open = 1;
            end else begin
               drops++;
               m_skip = !e;
            end
         end else if (m_open) begin
            if (m_len == MAX) begin
               drops++; m_open = 0; m_skip = !e;
            end else begin
               store(0, e, d);
               if (e) begin
                  m_cp[m_q] = beat_addr(m_q, m_len);
                  m_open = 0;
               end
            end
         end else if (m_skip) begin
            if (e) m_skip = 0;
         end else begin
            drops++;
         end
      end
      e_pulse = (drops != 0);
      m_dcnt = (m_dcnt + drops > 65535) ? 65535 : m_dcnt + drops;
   endtask

   task automatic compare();
      chk("hram_wen", int'(bus.hram_wen), int'(e_wen[1]));
      if (e_wen[1]) begin
         chk("hram_waddr", int'(bus.hram_waddr), e_waddr[1]);
         chk("hram_wdata", int'(bus.hram_wdata), e_wdata[1]);
      end
      chk("lram_wen", int'(bus.lram_wen), int'(e_wen[0]));
      if (e_wen[0]) begin
         chk("lram_waddr", int'(bus.lram_waddr), e_waddr[0]);
         chk("lram_wdata", int'(bus.lram_wdata), e_wdata[0]);
      end
      chk("high_real_waddr", int'(bus.high_real_waddr), m_pub[1]);
      chk("low_real_waddr", int'(bus.low_real_waddr), m_pub[0]);
      chk("drop_pulse", int'(bus.drop_pulse), int'(e_pulse));
      chk("drop_cnt", int'(bus.drop_cnt), m_dcnt);
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic beat(input bit s, input bit e, input bit q, input logic [7:0] d);
      bus.in_valid = 1; bus.in_sop = s; bus.in_eop = e; bus.in_qos = q; bus.in_data = d;
      cyc();
      bus.in_valid = 0;
   endtask

   task automatic idle(input int n);
      bus.in_valid = 0;
      repeat (n) cyc();
   endtask

   task automatic do_reset();
      bus.in_valid = 0;
      bus.hram_raddr = 11'(D - 1);
      bus.lram_raddr = 11'd0;
      rst_n = 0;
      m_reset();
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic pkt(input int len, input bit q);
      for (int k = 0; k < len; k++) beat(k == 0, k == len - 1, q, 8'(k));
   endtask

   initial begin
      int nw;
      bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0; bus.in_qos = 0; bus.in_data = 0;
      bus.hram_raddr = 11'(D - 1);
      bus.lram_raddr = 11'd0;
      rst_n = 0;
      m_reset();
      repeat (2) @(negedge clk);
      chk("rst hram_wen", int'(bus.hram_wen), 0);
      chk("rst hram_waddr", int'(bus.hram_waddr), 0);
      chk("rst lram_wdata", int'(bus.lram_wdata), 0);
      chk("rst high_real", int'(bus.high_real_waddr), 1143);
      chk("rst low_real", int'(bus.low_real_waddr), 0);
      chk("rst drop_cnt", int'(bus.drop_cnt), 0);
      chk("rst drop_pulse", int'(bus.drop_pulse), 0);
      rst_n = 1;

      // 4-beat high packet
      for (int k = 0; k < 4; k++) begin
         beat(k == 0, k == 3, 1, 8'(8'hA0 + k));
         chk("t1 waddr", int'(bus.hram_waddr), 1143 - k);
         chk("t1 lram_wen", int'(bus.lram_wen), 0);
         if (k == 0) chk("t1 first wdata", int'(bus.hram_wdata), 'h2A0);
         if (k == 3) chk("t1 last wdata", int'(bus.hram_wdata), 'h1A3);
      end
      chk("t1 real at eop", int'(bus.high_real_waddr), 1143);
      idle(1);
      chk("t1 real eop+1", int'(bus.high_real_waddr), 1143);
      idle(1);
      chk("t1 real eop+2", int'(bus.high_real_waddr), 1139);
      chk("t1 low untouched", int'(bus.low_real_waddr), 0);

      // Low pointer to 1143 via 1143 words, then a 1-word packet wraps it
      for (int p = 0; p < 18; p++) begin
         bus.lram_raddr = 11'(m_pub[0]);
         pkt((p < 17) ? 64 : 55, 0);
         idle(2);
      end
      chk("t2 low at 1143", int'(bus.low_real_waddr), 1143);
      bus.lram_raddr = 11'd1143;
      beat(1, 1, 0, 8'h55);
      chk("t2 waddr", int'(bus.lram_waddr), 1143);
      chk("t2 wdata", int'(bus.lram_wdata), 'h355);
      idle(2);
      chk("t2 low wrapped", int'(bus.low_real_waddr), 0);

      // Fill low RAM until free < 64, then drops and an abort+drop in one cycle
      do_reset();
      for (int p = 0; p < 17; p++) pkt(64, 0);
      idle(2);
      beat(1, 0, 0, 8'h11);
      chk("t3 drop_pulse", int'(bus.drop_pulse), 1);
      chk("t3 drop_cnt", int'(bus.drop_cnt), 1);
      chk("t3 no lram_wen", int'(bus.lram_wen), 0);
      beat(0, 0, 0, 8'h12);
      chk("t3 discard lram_wen", int'(bus.lram_wen), 0);
      beat(0, 1, 0, 8'h13);
      chk("t3 discard eop drop_cnt", int'(bus.drop_cnt), 1);
      beat(1, 0, 1, 8'h21);
      chk("t3 high accepted", int'(bus.hram_wen), 1);
      chk("t3 high addr", int'(bus.hram_waddr), 1143);
      beat(1, 1, 0, 8'h31);
      chk("t3 double drop cnt", int'(bus.drop_cnt), 3);
      chk("t3 double drop pulse", int'(bus.drop_pulse), 1);
      idle(1);
      chk("t3 pulse single", int'(bus.drop_pulse), 0);
      beat(1, 0, 1, 8'h41);
      chk("t3 rollback addr", int'(bus.hram_waddr), 1143);
      beat(0, 1, 1, 8'h42);
      chk("t3 second word addr", int'(bus.hram_waddr), 1142);
      idle(2);

      // Overlong packet: 65 beats then 3 more, eop last
      do_reset();
      nw = 0;
      for (int k = 0; k < 68; k++) begin
         beat(k == 0, k == 67, 1, 8'(k));
         if (bus.hram_wen) nw++;
      end
      chk("t4 writes", nw, 64);
      chk("t4 drop_cnt", int'(bus.drop_cnt), 1);
      idle(2);
      chk("t4 real unchanged", int'(bus.high_real_waddr), 1143);
      beat(1, 0, 1, 8'h77);
      chk("t4 restart addr", int'(bus.hram_waddr), 1143);
      beat(0, 1, 1, 8'h78);
      idle(2);

      // sop at beat 3 aborts the open packet
      do_reset();
      beat(1, 0, 1, 8'h01);
      beat(0, 0, 1, 8'h02);
      beat(1, 0, 1, 8'h03);
      chk("t5 new sop addr", int'(bus.hram_waddr), 1143);
      chk("t5 new sop wdata", int'(bus.hram_wdata), 'h203);
      chk("t5 drop_cnt", int'(bus.drop_cnt), 1);
      beat(0, 1, 1, 8'h04);
      chk("t5 eop addr", int'(bus.hram_waddr), 1142);
      idle(2);
      chk("t5 real", int'(bus.high_real_waddr), 1141);

      // Reset mid-packet
      beat(1, 0, 1, 8'h91);
      beat(0, 0, 1, 8'h92);
      bus.in_valid = 1; bus.in_sop = 0; bus.in_eop = 0; bus.in_data = 8'h93;
      rst_n = 0;
      #1;
      chk("t6 hram_wen", int'(bus.hram_wen), 0);
      chk("t6 high_real", int'(bus.high_real_waddr), 1143);
      chk("t6 drop_cnt", int'(bus.drop_cnt), 0);
      bus.in_valid = 0;
      m_reset();
      @(negedge clk);
      rst_n = 1;
      idle(2);
      chk("t6 no commit", int'(bus.high_real_waddr), 1143);
      beat(1, 1, 1, 8'h99);
      chk("t6 restart addr", int'(bus.hram_waddr), 1143);

      // Randomized traffic
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         bus.in_valid = ($urandom_range(0, 9) < 8);
         bus.in_sop   = (!m_open && !m_skip) ? ($urandom_range(0, 3) != 0)
                                             : ($urandom_range(0, 29) == 0);
         bus.in_eop   = ($urandom_range(0, 24) == 0) || (bus.in_sop && $urandom_range(0, 7) == 0);
         bus.in_qos   = 1'($urandom_range(0, 1));
         bus.in_data  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 15) == 0) bus.hram_raddr = 11'(m_pub[1]);
         if ($urandom_range(0, 15) == 0) bus.lram_raddr = 11'(m_pub[0]);
         if ($urandom_range(0, 99) == 0) bus.hram_raddr = 11'($urandom_range(0, D - 1));
         if ($urandom_range(0, 99) == 0) bus.lram_raddr = 11'($urandom_range(0, D - 1));
         cyc();
      end
      idle(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
